// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Holds the MEM/WB pipeline register and drives the
//   register-file write port seen by decode. It also owns the output-port
//   latch, and it reassembles a PC popped from the 16-bit stack as two beats
//   into a single PC restore request.
//
// Ports
//   clk                        rising-edge clock
//   reset                      asynchronous, active-low reset
//   wb_stall                   hold the MEM/WB register and freeze the pop FSM
//   wb_flush                   load a bubble; takes priority over wb_stall
//   mem_reg_write              instruction in MEM writes a register
//   mem_wb_sel                 00 ALU, 01 memory data, 10 in-port, 11 LDM immediate
//   mem_write_address          destination register
//   mem_alu_result             ALU result; this is also the OUT value
//   mem_read_data              data-memory read data; this is also the PC pop beat
//   inport_data                external in-port value
//   mem_ldm_value              LDM immediate
//   mem_outport_enable         OUT instruction
//   mem_pc_pop                 00 none, 01 high PC beat, 10 low PC beat, 11 illegal
//   reg_write_wb               register-file write enable
//   reg_write_address_from_wb  register-file write address
//   reg_write_data_from_wb     register-file write data
//   outport_value              latched output port
//   pc_restore_valid           one-cycle pulse when a full PC has been popped
//   pc_restore_value           {high beat, low beat}; holds between pulses
//   pc_pop_error               sticky pop-protocol violation flag
//
// Pop FSM states
//   state        | meaning
//   ST_IDLE      | no pop in progress
//   ST_HIGH_HELD | high PC half captured, waiting for the low beat

module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_stall,
  input  logic              wb_flush,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_wb_sel,
  input  logic [ADDR_W-1:0] mem_write_address,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] inport_data,
  input  logic [DATA_W-1:0] mem_ldm_value,
  input  logic              mem_outport_enable,
  input  logic [1:0]        mem_pc_pop,
  output logic              reg_write_wb,
  output logic [ADDR_W-1:0] reg_write_address_from_wb,
  output logic [DATA_W-1:0] reg_write_data_from_wb,
  output logic [DATA_W-1:0] outport_value,
  output logic              pc_restore_valid,
  output logic [PC_W-1:0]   pc_restore_value,
  output logic              pc_pop_error
);

  localparam logic [1:0] POP_NONE = 2'b00;
  localparam logic [1:0] POP_HIGH = 2'b01;
  localparam logic [1:0] POP_LOW  = 2'b10;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_HIGH_HELD = 1'b1
  } pop_state_t;

  // MEM/WB pipeline register
  logic              wb_reg_write;
  logic [1:0]        wb_sel;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_inport;
  logic [DATA_W-1:0] wb_ldm;
  logic              wb_outport_en;
  logic [1:0]        wb_pc_pop;

  // Pop FSM
  pop_state_t        state;
  pop_state_t        state_next;
  logic [DATA_W-1:0] held_high;
  logic [PC_W-1:0]   restore_last;
  logic              fire;
  logic              capture_high;
  logic              pop_error_event;

  // A flush clears only the control bits. The data fields are don't-care
  // under a bubble, so they simply keep their old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg_write  <= 1'b0;
      wb_sel        <= 2'b00;
      wb_addr       <= '0;
      wb_alu        <= '0;
      wb_mem_data   <= '0;
      wb_inport     <= '0;
      wb_ldm        <= '0;
      wb_outport_en <= 1'b0;
      wb_pc_pop     <= POP_NONE;
    end else if (wb_flush) begin
      wb_reg_write  <= 1'b0;
      wb_outport_en <= 1'b0;
      wb_pc_pop     <= POP_NONE;
    end else if (!wb_stall) begin
      wb_reg_write  <= mem_reg_write;
      wb_sel        <= mem_wb_sel;
      wb_addr       <= mem_write_address;
      wb_alu        <= mem_alu_result;
      wb_mem_data   <= mem_read_data;
      wb_inport     <= inport_data;
      wb_ldm        <= mem_ldm_value;
      wb_outport_en <= mem_outport_enable;
      wb_pc_pop     <= mem_pc_pop;
    end
  end

  // A stall does not gate the write enable. Re-writing the same value into
  // the register file while stalled has no effect.
  assign reg_write_wb              = wb_reg_write;
  assign reg_write_address_from_wb = wb_addr;

  always_comb begin
    reg_write_data_from_wb = wb_alu;
    case (wb_sel)
      2'b00:   reg_write_data_from_wb = wb_alu;
      2'b01:   reg_write_data_from_wb = wb_mem_data;
      2'b10:   reg_write_data_from_wb = wb_inport;
      default: reg_write_data_from_wb = wb_ldm;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outport_value <= '0;
    end else if (wb_outport_en && !wb_stall) begin
      outport_value <= wb_alu;
    end
  end

  // Pop FSM: state register and the registers it owns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      held_high    <= '0;
      restore_last <= '0;
      pc_pop_error <= 1'b0;
    end else begin
      state <= state_next;
      if (capture_high) begin
        held_high <= wb_mem_data;
      end
      if (fire) begin
        restore_last <= {held_high, wb_mem_data};
      end
      if (pop_error_event) begin
        pc_pop_error <= 1'b1;
      end
    end
  end

  // Pop FSM: next state. A flush aborts any pop in progress without raising
  // an error, whether or not a stall is also asserted.
  always_comb begin
    state_next = state;
    if (wb_flush) begin
      state_next = ST_IDLE;
    end else if (!wb_stall) begin
      case (state)
        ST_IDLE: begin
          if (wb_pc_pop == POP_HIGH) begin
            state_next = ST_HIGH_HELD;
          end
        end
        ST_HIGH_HELD: begin
          if (wb_pc_pop != POP_NONE) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Pop FSM: outputs
  always_comb begin
    fire            = 1'b0;
    capture_high    = 1'b0;
    pop_error_event = 1'b0;
    if (!wb_flush && !wb_stall) begin
      case (state)
        ST_IDLE: begin
          if (wb_pc_pop == POP_HIGH) begin
            capture_high = 1'b1;
          end else if (wb_pc_pop != POP_NONE) begin
            pop_error_event = 1'b1;
          end
        end
        ST_HIGH_HELD: begin
          if (wb_pc_pop == POP_LOW) begin
            fire = 1'b1;
          end else if (wb_pc_pop != POP_NONE) begin
            pop_error_event = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The pulse is combinational, so it appears in the first unstalled cycle
  // in which the low beat sits in WB. The registered copy keeps the value
  // steady between pulses.
  assign pc_restore_valid = fire;
  assign pc_restore_value = fire ? {held_high, wb_mem_data} : restore_last;

endmodule
